// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/halt/step sequencer and instruction-memory loader for the CPU core.
// Define BREAKPOINT_EN to enable the single-address breakpoint (SETBP command, bp_hit status bit).

module cpu_run_ctrl #(
    parameter int ADDR_W     = 8,
    parameter int RST_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [7:0]        cmd_data,
    input  logic [ADDR_W-1:0] cpu_pc,
    output logic              cpu_en,
    output logic              cpu_rst,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [7:0]        imem_wdata,
    output logic [7:0]        status
);

    typedef enum logic [2:0] {
        ST_HALT = 3'd0,
        ST_RUN  = 3'd1,
        ST_STEP = 3'd2,
        ST_LOAD = 3'd3,
        ST_CRST = 3'd4
    } state_e;

    localparam logic [2:0] OP_RUN   = 3'd1;
    localparam logic [2:0] OP_HALT  = 3'd2;
    localparam logic [2:0] OP_STEP  = 3'd3;
    localparam logic [2:0] OP_LOAD  = 3'd4;
    localparam logic [2:0] OP_RESET = 3'd5;

    state_e            state_q, state_d;
    logic [3:0]        crst_cnt_q, crst_cnt_d;
    logic [7:0]        ld_cnt_q, ld_cnt_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [7:0]        imem_wdata_q, imem_wdata_d;
    logic              imem_we_q, imem_we_d;
    logic              cmd_ready_q, cpu_rst_q, load_busy_q;
    logic              accept, bp_match, bp_hit_q;

    assign accept = cmd_valid & cmd_ready_q;

`ifdef BREAKPOINT_EN
    localparam logic [2:0] OP_SETBP = 3'd6;

    logic              bp_valid_q;
    logic [ADDR_W-1:0] bp_addr_q;

    assign bp_match = bp_valid_q && (cpu_pc == bp_addr_q);

    // A hit sets bp_hit even when a HALT command lands in the same cycle; only RUN clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bp_valid_q <= 1'b0;
            bp_addr_q  <= '0;
            bp_hit_q   <= 1'b0;
        end else begin
            if (accept && state_q == ST_HALT && cmd_op == OP_SETBP) begin
                bp_valid_q <= 1'b1;
                bp_addr_q  <= cmd_data[ADDR_W-1:0];
            end
            if (state_q == ST_RUN && bp_match)
                bp_hit_q <= 1'b1;
            else if (accept && state_q == ST_HALT && cmd_op == OP_RUN)
                bp_hit_q <= 1'b0;
        end
    end
`else
    logic unused_pc;
    assign unused_pc = ^cpu_pc;
    assign bp_match  = 1'b0;
    assign bp_hit_q  = 1'b0;
`endif

    // The instruction at a breakpoint address is suppressed in the very cycle the PC reaches it.
    assign cpu_en = ((state_q == ST_RUN) && !bp_match) || (state_q == ST_STEP);

    always_comb begin
        state_d      = state_q;
        crst_cnt_d   = crst_cnt_q;
        ld_cnt_d     = ld_cnt_q;
        imem_addr_d  = imem_we_q ? imem_addr_q + ADDR_W'(1) : imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        imem_we_d    = 1'b0;
        case (state_q)
            ST_HALT: begin
                if (accept) begin
                    case (cmd_op)
                        OP_RUN:  state_d = ST_RUN;
                        OP_STEP: state_d = ST_STEP;
                        OP_LOAD: begin
                            if (cmd_data != 8'd0) begin
                                state_d     = ST_LOAD;
                                ld_cnt_d    = cmd_data;
                                imem_addr_d = '0;
                            end
                        end
                        OP_RESET: begin
                            state_d    = ST_CRST;
                            crst_cnt_d = 4'(RST_CYCLES);
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (accept && cmd_op == OP_RESET) begin
                    state_d    = ST_CRST;
                    crst_cnt_d = 4'(RST_CYCLES);
                end else if ((accept && cmd_op == OP_HALT) || bp_match) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: state_d = ST_HALT;
            ST_LOAD: begin
                if (accept) begin
                    imem_we_d    = 1'b1;
                    imem_wdata_d = cmd_data;
                    ld_cnt_d     = ld_cnt_q - 8'd1;
                    if (ld_cnt_q == 8'd1)
                        state_d = ST_HALT;
                end
            end
            ST_CRST: begin
                if (crst_cnt_q <= 4'd1)
                    state_d = ST_HALT;
                else
                    crst_cnt_d = crst_cnt_q - 4'd1;
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_CRST;
            crst_cnt_q   <= 4'(RST_CYCLES);
            ld_cnt_q     <= 8'd0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 8'd0;
            imem_we_q    <= 1'b0;
            cmd_ready_q  <= 1'b0;
            cpu_rst_q    <= 1'b1;
            load_busy_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            crst_cnt_q   <= crst_cnt_d;
            ld_cnt_q     <= ld_cnt_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            imem_we_q    <= imem_we_d;
            cmd_ready_q  <= (state_d == ST_HALT) || (state_d == ST_RUN) || (state_d == ST_LOAD);
            cpu_rst_q    <= (state_d == ST_CRST);
            load_busy_q  <= (state_d == ST_LOAD);
        end
    end

    assign cmd_ready  = cmd_ready_q;
    assign cpu_rst    = cpu_rst_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign status     = {bp_hit_q, load_busy_q, 3'b000, state_q};

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: behavioural model compared every cycle plus directed literal checks.
// Define BREAKPOINT_EN to also exercise the breakpoint scenario.

module tb_cpu_run_ctrl;

    localparam int ADDR_W     = 8;
    localparam int RST_CYCLES = 4;
    localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_LOAD = 3, M_CRST = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = 3'd0;
    logic [7:0]        cmd_data = 8'd0;
    logic [ADDR_W-1:0] cpu_pc = '0;
    logic              cpu_en, cpu_rst, imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_wdata, status;

    int checks = 0;
    int errors = 0;

    cpu_run_ctrl #(.ADDR_W(ADDR_W), .RST_CYCLES(RST_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cpu_pc(cpu_pc), .cpu_en(cpu_en),
        .cpu_rst(cpu_rst), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .status(status)
    );

    always #5 clk = ~clk;

    // Behavioural model of the controller plus a trivial core whose PC counts enabled cycles.
    int  mMode, mCrstLeft, mLoadLeft, mNextAddr, mBpAddr, mWAddr, mWData;
    bit  mBpValid, mBpHit, mWe;
    bit  modelOn = 1'b0;
    logic [7:0] wrA[$];
    logic [7:0] wrD[$];

    task automatic mReset();
        mMode = M_CRST; mCrstLeft = RST_CYCLES; mLoadLeft = 0; mNextAddr = 0;
        mBpValid = 1'b0; mBpAddr = 0; mBpHit = 1'b0; mWe = 1'b0; mWAddr = 0; mWData = 0;
    endtask

    function automatic bit expReady();
        return (mMode == M_HALT) || (mMode == M_RUN) || (mMode == M_LOAD);
    endfunction

    function automatic bit expEn();
        return ((mMode == M_RUN) && !(mBpValid && int'(cpu_pc) == mBpAddr)) || (mMode == M_STEP);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge rst_n) mReset();

    always @(posedge clk) begin : model
        bit acc, en, match;
        if (!rst_n) begin
            mReset();
            cpu_pc <= '0;
        end else begin
            match = mBpValid && (int'(cpu_pc) == mBpAddr);
            en    = expEn();
            acc   = cmd_valid && expReady();
            if (mMode == M_CRST) cpu_pc <= '0;
            else if (en)         cpu_pc <= cpu_pc + 8'd1;
            mWe = 1'b0;
            case (mMode)
                M_HALT: if (acc) begin
                    if (cmd_op == 3'd1) begin mMode = M_RUN; mBpHit = 1'b0; end
                    else if (cmd_op == 3'd3) mMode = M_STEP;
                    else if (cmd_op == 3'd4 && cmd_data != 8'd0) begin
                        mMode = M_LOAD; mLoadLeft = int'(cmd_data); mNextAddr = 0;
                    end
                    else if (cmd_op == 3'd5) begin mMode = M_CRST; mCrstLeft = RST_CYCLES; end
`ifdef BREAKPOINT_EN
                    else if (cmd_op == 3'd6) begin mBpValid = 1'b1; mBpAddr = int'(cmd_data); end
`endif
                end
                M_RUN: begin
                    if (match) mBpHit = 1'b1;
                    if (acc && cmd_op == 3'd5) begin mMode = M_CRST; mCrstLeft = RST_CYCLES; end
                    else if ((acc && cmd_op == 3'd2) || match) mMode = M_HALT;
                end
                M_STEP: mMode = M_HALT;
                M_LOAD: if (acc) begin
                    mWe = 1'b1; mWAddr = mNextAddr; mWData = int'(cmd_data);
                    mNextAddr = (mNextAddr + 1) % (1 << ADDR_W);
                    mLoadLeft--;
                    if (mLoadLeft == 0) mMode = M_HALT;
                end
                default: begin
                    mCrstLeft--;
                    if (mCrstLeft == 0) mMode = M_HALT;
                end
            endcase
        end
    end

    // Every cycle: DUT outputs against the model; write data/address only matter on a strobe.
    always @(negedge clk) if (modelOn) begin
        checkOutput("cpu_en", 32'(cpu_en), 32'(expEn()));
        checkOutput("cpu_rst", 32'(cpu_rst), 32'(mMode == M_CRST));
        checkOutput("cmd_ready", 32'(cmd_ready), 32'(expReady()));
        checkOutput("imem_we", 32'(imem_we), 32'(mWe));
        if (mWe) begin
            checkOutput("imem_addr", 32'(imem_addr), 32'(mWAddr));
            checkOutput("imem_wdata", 32'(imem_wdata), 32'(mWData));
        end
        checkOutput("status", 32'(status), 32'({mBpHit, mMode == M_LOAD, 3'b000, 3'(mMode)}));
        if (imem_we === 1'b1) begin
            wrA.push_back(imem_addr);
            wrD.push_back(imem_wdata);
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [7:0] data);
        bit done = 1'b0;
        @(posedge clk); #1;
        cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (cmd_ready === 1'b1) begin
                @(posedge clk); #1;
                done = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("[TB] FAIL handshake: op %0d never accepted", op);
        end
    endtask

    task automatic releaseReset();
        int cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (cpu_rst !== 1'b1) break;
            cnt++;
            @(negedge clk);
        end
        checkOutput("crst_cycles", 32'(cnt), 32'd4);
        checkOutput("post_rst_status", 32'(status), 32'h00);
        checkOutput("post_rst_ready", 32'(cmd_ready), 32'd1);
        checkOutput("post_rst_en", 32'(cpu_en), 32'd0);
    endtask

    initial begin : watchdog
        #400000;
        $display("[TB] FAIL watchdog: simulation timed out");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stim
        int cnt;
        int pcStart;
        mReset();
        modelOn = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("rst_status", 32'(status), 32'h04);
        checkOutput("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("rst_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst_imem_addr", 32'(imem_addr), 32'd0);
        releaseReset();

        // Three-byte load; data beats carry unrelated opcodes that must be ignored.
        wrA.delete(); wrD.delete();
        applyStimulus(3'd4, 8'd3);
        @(negedge clk);
        checkOutput("load_status", 32'(status), 32'h43);
        applyStimulus(3'd5, 8'hA1);
        applyStimulus(3'd1, 8'hB2);
        applyStimulus(3'd2, 8'hC3);
        repeat (2) @(negedge clk);
        checkOutput("load_count", 32'(wrA.size()), 32'd3);
        if (wrA.size() == 3) begin
            checkOutput("load_a0", 32'(wrA[0]), 32'd0);
            checkOutput("load_d0", 32'(wrD[0]), 32'hA1);
            checkOutput("load_a1", 32'(wrA[1]), 32'd1);
            checkOutput("load_d1", 32'(wrD[1]), 32'hB2);
            checkOutput("load_a2", 32'(wrA[2]), 32'd2);
            checkOutput("load_d2", 32'(wrD[2]), 32'hC3);
        end
        checkOutput("load_done_status", 32'(status), 32'h00);

        applyStimulus(3'd4, 8'd0);
        @(negedge clk);
        checkOutput("load0_status", 32'(status), 32'h00);

        // Single step.
        applyStimulus(3'd3, 8'd0);
        @(negedge clk);
        checkOutput("step_ready", 32'(cmd_ready), 32'd0);
        cnt = cpu_en ? 1 : 0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_en) cnt++;
        end
        checkOutput("step_en_cycles", 32'(cnt), 32'd1);
        checkOutput("step_status", 32'(status), 32'h00);

        // Free run for ten cycles, then halt.
        pcStart = int'(cpu_pc);
        applyStimulus(3'd1, 8'd0);
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (cpu_en) cnt++;
        end
        checkOutput("run_en_cycles", 32'(cnt), 32'd10);
        applyStimulus(3'd2, 8'd0);
        @(negedge clk);
        checkOutput("halt_en", 32'(cpu_en), 32'd0);
        checkOutput("halt_status", 32'(status), 32'h00);
        checkOutput("run_pc_advanced", 32'(int'(cpu_pc) >= pcStart + 10), 32'd1);

`ifdef BREAKPOINT_EN
        applyStimulus(3'd5, 8'd0);
        cnt = 0;
        while (status !== 8'h00 && cnt < 20) begin @(negedge clk); cnt++; end
        checkOutput("bp_pc_reset", 32'(cpu_pc), 32'd0);
        applyStimulus(3'd6, 8'h05);
        applyStimulus(3'd1, 8'd0);
        cnt = 0;
        while (status !== 8'h80 && cnt < 40) begin @(negedge clk); cnt++; end
        checkOutput("bp_status", 32'(status), 32'h80);
        checkOutput("bp_pc", 32'(cpu_pc), 32'd5);
        checkOutput("bp_en", 32'(cpu_en), 32'd0);
        applyStimulus(3'd3, 8'd0);
        repeat (3) @(negedge clk);
        checkOutput("bp_step_pc", 32'(cpu_pc), 32'd6);
        checkOutput("bp_step_status", 32'(status), 32'h80);
`endif

        // Asynchronous reset in the middle of a load, while a write strobe is active.
        applyStimulus(3'd4, 8'd4);
        applyStimulus(3'd0, 8'h5A);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midload_we", 32'(imem_we), 32'd0);
        checkOutput("midload_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("midload_status", 32'(status), 32'h04);
        checkOutput("midload_addr", 32'(imem_addr), 32'd0);
        repeat (2) @(posedge clk);
        releaseReset();

        // Longest possible load: 255 bytes ending at address 254.
        wrA.delete(); wrD.delete();
        applyStimulus(3'd4, 8'd255);
        for (int i = 0; i < 255; i++) applyStimulus(3'd0, 8'(i));
        repeat (2) @(negedge clk);
        checkOutput("long_count", 32'(wrA.size()), 32'd255);
        if (wrA.size() == 255) begin
            checkOutput("long_last_addr", 32'(wrA[254]), 32'd254);
            checkOutput("long_last_data", 32'(wrD[254]), 32'd254);
        end
        checkOutput("long_status", 32'(status), 32'h00);

        modelOn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
